// File: rtl/press_event_counter_if.sv
// Signal bundle between the debouncer side and the press event counter.
// The counter is the slave: it consumes db and produces ticks, count and busy.
interface press_event_counter_if;
  logic        db;
  logic        press_tick;
  logic        release_tick;
  logic        long_tick;
  logic        ovf_tick;
  logic [15:0] count;
  logic        busy;

  modport slave (
    input  db,
    output press_tick, release_tick, long_tick, ovf_tick, count, busy
  );

  modport master (
    output db,
    input  press_tick, release_tick, long_tick, ovf_tick, count, busy
  );
endinterface

// File: rtl/press_event_counter.sv
// Press event counter: classifies debounced presses as short or long,
// emits one-cycle event ticks and keeps a 4-digit BCD count of short presses.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   S_IDLE      | button released, waiting for a rising edge on db
//   S_PRESSED   | press accepted, timing the hold against LONG_TICKS
//   S_LONG_HELD | press became long (count cleared), waiting for release
module press_event_counter #(
  parameter int N          = 19,
  parameter int LONG_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  press_event_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_HELD = 2'd2
  } state_t;

  localparam logic [7:0] LONG_LAST = 8'(LONG_TICKS - 1);

  state_t        r_state;
  logic          r_db_d;
  logic [N-1:0]  r_presc;
  logic [7:0]    r_hold_cnt;
  logic [15:0]   r_count;
  logic          r_press_tick;
  logic          r_release_tick;
  logic          r_long_tick;
  logic          r_ovf_tick;

  state_t        w_state_nxt;
  logic [N-1:0]  w_presc_nxt;
  logic [7:0]    w_hold_nxt;
  logic [15:0]   w_count_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_long_nxt;
  logic          w_ovf_nxt;

  logic          w_rise;
  logic          w_fall;
  logic          w_m_tick;
  logic [15:0]   w_count_inc;
  logic          w_count_wrap;

  assign w_rise       = bus.db & ~r_db_d;
  assign w_fall       = ~bus.db & r_db_d;
  assign w_m_tick     = &r_presc;
  assign w_count_wrap = (r_count == 16'h9999);

  // BCD increment of the count: ripple a carry through digits that sit at 9.
  always_comb begin : bcd_inc
    logic carry;
    carry       = 1'b1;
    w_count_inc = r_count;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r_count[d*4 +: 4] == 4'd9) begin
          w_count_inc[d*4 +: 4] = 4'd0;
        end else begin
          w_count_inc[d*4 +: 4] = r_count[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Next-state and next-output decode; fall is checked before the long
  // timeout so a release coinciding with the final m_tick counts as short.
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc + 1'b1;
    w_hold_nxt    = r_hold_cnt;
    w_count_nxt   = r_count;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_ovf_nxt     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_PRESSED;
          w_press_nxt = 1'b1;
          w_presc_nxt = '0;
          w_hold_nxt  = 8'd0;
        end
      end
      S_PRESSED: begin
        if (w_m_tick) begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
        if (w_fall) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
          w_count_nxt   = w_count_inc;
          w_ovf_nxt     = w_count_wrap;
        end else if (w_m_tick && (r_hold_cnt == LONG_LAST)) begin
          w_state_nxt = S_LONG_HELD;
          w_long_nxt  = 1'b1;
          w_count_nxt = 16'h0000;
        end
      end
      S_LONG_HELD: begin
        if (w_fall) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any press in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and tick registers; db_d resets high so a held button is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_db_d         <= 1'b1;
      r_presc        <= '0;
      r_hold_cnt     <= 8'd0;
      r_count        <= 16'h0000;
      r_press_tick   <= 1'b0;
      r_release_tick <= 1'b0;
      r_long_tick    <= 1'b0;
      r_ovf_tick     <= 1'b0;
    end else begin
      r_db_d         <= bus.db;
      r_presc        <= w_presc_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_count        <= w_count_nxt;
      r_press_tick   <= w_press_nxt;
      r_release_tick <= w_release_nxt;
      r_long_tick    <= w_long_nxt;
      r_ovf_tick     <= w_ovf_nxt;
    end
  end

  assign bus.press_tick   = r_press_tick;
  assign bus.release_tick = r_release_tick;
  assign bus.long_tick    = r_long_tick;
  assign bus.ovf_tick     = r_ovf_tick;
  assign bus.count        = r_count;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_press_event_counter.sv
// Directed bench for press_event_counter with N=3, LONG_TICKS=4
// (one m_tick every 8 clocks, long press after 32 clocks of hold).
module tb_press_event_counter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  press_event_counter_if bus ();

  press_event_counter #(
    .N          (3),
    .LONG_TICKS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, landing 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Fastest legal short press: db high for one cycle, no checks.
  task automatic quick_press();
    bus.db = 1'b1;
    tick(1);
    bus.db = 1'b0;
    tick(1);
  endtask

  // Short press with checks on press acceptance and on the release cycle.
  task automatic press_and_check(input string tag, input logic [15:0] exp_count,
                                 input logic exp_ovf);
    bus.db = 1'b1;
    tick(1);
    chk1({tag, "_press_tick"}, bus.press_tick, 1'b1);
    bus.db = 1'b0;
    tick(1);
    chk1({tag, "_release_tick"}, bus.release_tick, 1'b1);
    chk16({tag, "_count"}, bus.count, exp_count);
    chk1({tag, "_ovf_tick"}, bus.ovf_tick, exp_ovf);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus.db   = 1'b0;

    // 1. reset, then quiet idle
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk1("idle_quiet", bus.press_tick | bus.release_tick | bus.long_tick |
                         bus.ovf_tick | bus.busy, 1'b0);
    end
    chk16("reset_count", bus.count, 16'h0000);

    // 2. short press of 10 cycles
    bus.db = 1'b1;
    tick(1);
    chk1("t2_press_tick", bus.press_tick, 1'b1);
    chk1("t2_busy_on", bus.busy, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk1("t2_press_once", bus.press_tick, 1'b0);
      chk1("t2_busy_hold", bus.busy, 1'b1);
      chk1("t2_no_release", bus.release_tick, 1'b0);
    end
    bus.db = 1'b0;
    tick(1);
    chk1("t2_release_tick", bus.release_tick, 1'b1);
    chk1("t2_busy_off", bus.busy, 1'b0);
    chk16("t2_count", bus.count, 16'h0001);
    tick(1);
    chk1("t2_release_once", bus.release_tick, 1'b0);

    // 3. preload 0037, then a 40-cycle long press
    for (int i = 0; i < 36; i++) quick_press();
    chk16("t3_preload", bus.count, 16'h0037);
    bus.db = 1'b1;
    tick(1);
    chk1("t3_press_tick", bus.press_tick, 1'b1);
    for (int e = 1; e <= 40; e++) begin
      tick(1);
      chk1("t3_long_tick", bus.long_tick, (e == 32));
      chk16("t3_count", bus.count, (e >= 32) ? 16'h0000 : 16'h0037);
      chk1("t3_busy", bus.busy, 1'b1);
    end
    bus.db = 1'b0;
    tick(1);
    chk1("t3_release_tick", bus.release_tick, 1'b1);
    chk1("t3_long_once", bus.long_tick, 1'b0);
    chk16("t3_count_after", bus.count, 16'h0000);
    chk1("t3_busy_off", bus.busy, 1'b0);

    // 4. BCD carries and 9999 wrap
    for (int i = 0; i < 9; i++) quick_press();
    chk16("t4_0009", bus.count, 16'h0009);
    press_and_check("t4_0010", 16'h0010, 1'b0);
    for (int i = 0; i < 89; i++) quick_press();
    chk16("t4_0099", bus.count, 16'h0099);
    press_and_check("t4_0100", 16'h0100, 1'b0);
    for (int i = 0; i < 9899; i++) quick_press();
    chk16("t4_9999", bus.count, 16'h9999);
    press_and_check("t4_wrap", 16'h0000, 1'b1);
    tick(1);
    chk1("t4_ovf_once", bus.ovf_tick, 1'b0);

    // 5. fall coincides with the final m_tick: short press wins
    bus.db = 1'b1;
    tick(1);
    chk1("t5_press_tick", bus.press_tick, 1'b1);
    for (int e = 1; e <= 31; e++) begin
      tick(1);
      chk1("t5_no_long_early", bus.long_tick, 1'b0);
    end
    bus.db = 1'b0;
    tick(1);
    chk1("t5_release_tick", bus.release_tick, 1'b1);
    chk1("t5_no_long", bus.long_tick, 1'b0);
    chk16("t5_count", bus.count, 16'h0001);
    chk1("t5_idle", bus.busy, 1'b0);
    tick(1);
    chk1("t5_no_long_late", bus.long_tick, 1'b0);

    // 6a. button held through reset is ignored
    bus.db = 1'b1;
    reset  = 1'b0;
    tick(2);
    reset = 1'b1;
    chk16("t6_reset_count", bus.count, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk1("t6_held_no_press", bus.press_tick, 1'b0);
      chk1("t6_held_not_busy", bus.busy, 1'b0);
    end
    bus.db = 1'b0;
    tick(2);
    press_and_check("t6_repress", 16'h0001, 1'b0);

    // 6b. reset mid-press aborts silently
    tick(1);
    bus.db = 1'b1;
    tick(1);
    chk1("t6b_busy", bus.busy, 1'b1);
    tick(3);
    reset = 1'b0;
    tick(1);
    chk1("t6b_busy_off", bus.busy, 1'b0);
    chk16("t6b_count", bus.count, 16'h0000);
    chk1("t6b_no_release", bus.release_tick, 1'b0);
    reset  = 1'b1;
    bus.db = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk1("t6b_no_release_after", bus.release_tick, 1'b0);
      chk16("t6b_count_after", bus.count, 16'h0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/press_event_counter.md
Name: press_event_counter

Overview:
- Sits directly downstream of the switch debouncer; consumes its clean level output `db`.
- Classifies each press as short or long and emits single-cycle event ticks.
- Keeps a 4-digit BCD count of short presses; a long press clears the count.
- The count feeds the display-multiplex stage.

Parameters:
- N, 19: prescaler width; the hold-timing tick fires once every 2^N clocks.
- LONG_TICKS, 8: number of prescaler ticks `db` must stay high for a press to become long (range 1..255).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- db  input  1  debounced switch level from the debouncer.
- press_tick  output  1  one-cycle pulse when a press is accepted.
- release_tick  output  1  one-cycle pulse on any release.
- long_tick  output  1  one-cycle pulse when a press becomes long.
- ovf_tick  output  1  one-cycle pulse when the count wraps 9999->0000.
- count  output  16  BCD count; digit 3 is [15:12], digit 0 is [3:0].
- busy  output  1  high while the button is held (state is not IDLE).

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is sampled only at a clk edge with reset==0.
  - Reset values: state=IDLE, db_d=1, prescaler=0, hold_cnt=0, count=16'h0000, all ticks 0, busy=0.
  - db_d resetting to 1 means a button held through reset is not counted; it must be released and pressed again.
  - Reset mid-press aborts the press silently: no release_tick, no increment.
- Edge detect:
  - db_d registers db every cycle.
  - rise = db & ~db_d; fall = ~db & db_d.
- Prescaler:
  - N-bit free-running up-counter.
  - m_tick = (prescaler == 2^N-1).
  - Forced to 0 on the edge that enters PRESSED, so hold time is measured from acceptance of the press.
- hold_cnt:
  - 8 bits, cleared on entry to PRESSED.
  - Increments on m_tick while in PRESSED.
- FSM states: IDLE, PRESSED, LONG_HELD. All outputs are registered.
  - IDLE:
    - rise -> PRESSED; press_tick=1 in the following cycle.
    - Otherwise stay.
  - PRESSED:
    - fall -> IDLE; release_tick=1 next cycle; count increments (BCD).
    - Else if m_tick and hold_cnt==LONG_TICKS-1 -> LONG_HELD; long_tick=1 next cycle; count set to 0000 on the same edge.
    - Else stay.
  - LONG_HELD:
    - fall -> IDLE; release_tick=1 next cycle; count unchanged.
    - Otherwise stay; no further long_tick.
- Simultaneous events: in PRESSED, if fall and the final m_tick coincide, fall wins. The press is treated as short, so the count increments and no long_tick is issued.
- BCD increment:
  - Digit 0 is incremented.
  - Any digit going 9->0 carries into the next digit.
  - 9999 -> 0000 with ovf_tick=1 in the same cycle as release_tick.
  - Digits never take values A-F.
- Latency: with press accepted at edge k, long_tick is high in the cycle after edge k + 2^N*LONG_TICKS.
- busy: high in every cycle where the registered state is PRESSED or LONG_HELD.
- Tick pulses are exactly one cycle wide; at most one of press_tick and release_tick is high in any cycle.
- Input assumption: `db` arrives from the debouncer already glitch-free, so no further filtering is done here. A one-cycle db high pulse is still handled legally: press_tick followed by release_tick, and count+1.

Test Plan (N=3, LONG_TICKS=4 unless noted):
1. Reset low 2 cycles, then release reset; hold db=0 for 20 cycles -> count=0000, all ticks 0, busy=0.
2. db rises before edge k, falls after 10 cycles -> press_tick high in cycle k+1; release_tick one cycle after the fall; count=0001; busy high only between the two.
3. Press held 40 cycles from acceptance at edge k -> long_tick high only in cycle after edge k+32; count=0000 (preloaded 0037 via prior presses); release gives release_tick, count stays 0000.
4. Preload 0009 and 0099 via short presses, then one more press each -> 0010 and 0100; preload 9999, one short press -> count=0000 with ovf_tick=1 coincident with release_tick.
5. Fall at exactly the edge of the 4th m_tick (edge k+32) -> no long_tick; count increments by 1; state IDLE.
6. db=1 held through reset, reset released -> no press_tick; release, then press again -> press_tick and count=0001 after release. Separately, assert reset mid-press in PRESSED -> count=0000, no release_tick, busy=0 next cycle.
